// File: rtl/csa3_pipe_accum_if.sv
// rtl/csa3_pipe_accum_if.sv - Beat-in / result-out handshake bundle for csa3_pipe_accum
interface csa3_pipe_accum_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             acc_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    // Producer of operands and consumer of results (partial-product side / MAC register side)
    modport master (
        output in_valid, a, b, c, acc_en, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    // The summing block itself
    modport slave (
        input  in_valid, a, b, c, acc_en, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/csa3_pipe_accum.sv
// rtl/csa3_pipe_accum.sv - Two-stage carry-save three-operand adder with running accumulate
module csa3_pipe_accum #(
    parameter int WIDTH = 12,
    parameter bit SAT   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    csa3_pipe_accum_if.slave   bus
);
    // Stage 1: carry-save form of a+b+c
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_sum;
    logic [WIDTH-1:0] r_s1_car;
    logic             r_s1_acc;

    // Stage 2: output register; r_sum doubles as the accumulator source
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_ovf;

    logic             w_s2_fire;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [WIDTH+1:0] w_t;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_xor3;
    logic [WIDTH-1:0] w_maj3;

    // Stage 2 may advance when the output slot is empty or is being drained this cycle
    assign w_s2_fire  = r_s1_valid && (!r_out_valid || bus.out_ready);
    // Ready looks through stage 2 so a full pipe still streams one beat per cycle
    assign w_in_ready = !rst && (!r_s1_valid || w_s2_fire);
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

    assign w_xor3 = bus.a ^ bus.b ^ bus.c;
    assign w_maj3 = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);

    // Two extra bits hold the worst case 3*(2^W-1) + (2^W-1) without loss
    assign w_t = {2'b00, r_s1_sum}
               + {1'b0, r_s1_car, 1'b0}
               + (r_s1_acc ? {2'b00, r_sum} : {(WIDTH+2){1'b0}});
    assign w_ovf      = |w_t[WIDTH+1:WIDTH];
    assign w_sum_next = (SAT && w_ovf) ? {WIDTH{1'b1}} : w_t[WIDTH-1:0];

    // Stage 1 register: capture compressed operands on input handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_car   <= '0;
            r_s1_acc   <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_sum   <= w_xor3;
            r_s1_car   <= w_maj3;
            r_s1_acc   <= bus.acc_en;
        end else if (w_s2_fire) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2 register: resolve carries, fold in the previous result, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
        end else if (w_s2_fire) begin
            r_out_valid <= 1'b1;
            r_sum       <= w_sum_next;
            r_ovf       <= w_ovf;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.ovf       = r_ovf;
endmodule
